// File: rtl/uart_pkg.sv
// Shared UART definitions for the harness receive and transmit paths.
// Latency: none (types and constant helpers only).
// Backpressure: not applicable.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_t;

  // Clocks per serial bit; integer division so the bit period rounds down.
  function automatic int clocks_per_bit(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction

endpackage

// File: rtl/uart_input_synchronizer.sv
// Two-flop synchronizer bringing the asynchronous serial line into the clock domain.
// Latency: 2 clocks from pin to synced output.
// Backpressure: none; both flops reset to the idle-high line level.
module uart_input_synchronizer (
  input  logic clock,
  input  logic reset,
  input  logic line,
  output logic synced
);

  logic stage;

  // Shift the line through two flops; reset to 1 so a reset never looks like a start bit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stage  <= 1'b1;
      synced <= 1'b1;
    end else begin
      stage  <= line;
      synced <= stage;
    end
  end

endmodule

// File: rtl/uart_byte_receiver.sv
// Deserializes the host UART line into bytes, flagging framing errors and overruns.
// Latency: HALF_BIT + 9*CLOCKS_PER_BIT + 1 clocks from synchronized start edge to out_valid.
// Backpressure: one-entry buffer; a byte finishing while the buffer is full is dropped with an overrun pulse.
module uart_byte_receiver
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_receive,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int CLOCKS_PER_BIT = clocks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int HALF_BIT       = CLOCKS_PER_BIT / 2;
  localparam int COUNT_WIDTH    = $clog2(CLOCKS_PER_BIT);

  localparam logic [COUNT_WIDTH-1:0] HALF_LAST = COUNT_WIDTH'(HALF_BIT - 1);
  localparam logic [COUNT_WIDTH-1:0] BIT_LAST  = COUNT_WIDTH'(CLOCKS_PER_BIT - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  // Fewer than 4 clocks per bit leaves no room to find the middle of a bit.
  generate
    if (CLOCKS_PER_BIT < 4) begin : g_rate_check
      $error("uart_byte_receiver: CLOCKS_PER_BIT must be at least 4");
    end
  endgenerate

  logic                   rx;
  uart_state_t            state;
  logic [COUNT_WIDTH-1:0] clock_count;
  logic [2:0]             bit_count;
  logic [7:0]             shift;
  logic                   deliver;

  uart_input_synchronizer u_sync (
    .clock  (clock),
    .reset  (reset),
    .line   (uart_receive),
    .synced (rx)
  );

  // A good stop bit hands the assembled byte to the output buffer in the same cycle.
  assign deliver = (state == STOP) && (clock_count == BIT_LAST) && rx;

  // Frame state machine: centre on the start bit, then sample each following bit mid-period.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      clock_count   <= '0;
      bit_count     <= '0;
      shift         <= '0;
      framing_error <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx) begin
            state       <= START;
            clock_count <= '0;
            bit_count   <= '0;
          end
        end
        START: begin
          if (clock_count == HALF_LAST) begin
            clock_count <= '0;
            state       <= rx ? IDLE : DATA;
          end else begin
            clock_count <= clock_count + COUNT_ONE;
          end
        end
        DATA: begin
          if (clock_count == BIT_LAST) begin
            clock_count      <= '0;
            shift[bit_count] <= rx;
            if (bit_count == 3'd7) begin
              state <= STOP;
            end else begin
              bit_count <= bit_count + 3'd1;
            end
          end else begin
            clock_count <= clock_count + COUNT_ONE;
          end
        end
        STOP: begin
          if (clock_count == BIT_LAST) begin
            clock_count <= '0;
            if (rx) begin
              state <= IDLE;
            end else begin
              state         <= BREAK;
              framing_error <= 1'b1;
            end
          end else begin
            clock_count <= clock_count + COUNT_ONE;
          end
        end
        BREAK: begin
          if (rx) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-entry output buffer; a simultaneous consume frees the slot for the new byte.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver) begin
        if (!out_valid || out_ready) begin
          out_data  <= shift;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
